player_answer_judge: RTL
========================

# player_answer_judge

Consumes the arbitrated buzz-in from the controller front end (`playerInputFlag`, `firstPlayerFlag`, `switchInput`) and judges one round. The CPU arms it with a target hex byte. It latches the first buzzing player and that player's switch value, compares the value against the target, and keeps per-player scores. It then drives the player LED outputs back toward the GPIO header for a fixed display window. It sits between the controller input block and the CPU I/O register map.

## Interface

Parameters:
- `LOCK_CYCLES`, default 50000000: length of the result-display window in clk cycles (1 s at 50 MHz). Must be ≥ 1.

Ports:
- `clk` input 1: system clock, 50 MHz.
- `reset` input 1: asynchronous, active-high reset.
- `start` input 1: single-cycle pulse from the CPU that arms a round.
- `target` input 8: expected answer; sampled on the accepted `start` cycle.
- `playerInputFlag` input 1: buzz-in present; asynchronous to clk.
- `firstPlayerFlag` input 2: index of the buzzing player (0–3); asynchronous.
- `switchInput` input 8: buzzing player's switch value; asynchronous.
- `busy` output 1: high while the FSM is not IDLE.
- `done` output 1: one-cycle pulse when a round completes.
- `correct` output 1: result of the last judged round; held until the next judgement.
- `winner` output 2: player index latched in the last round.
- `answer` output 8: switch value latched in the last round.
- `scores` output 32: `{s3,s2,s1,s0}`, 8 bits per player.
- `p_led` output 4: one-hot player LED drive, active high.

## Operation

- Input conditioning: `playerInputFlag`, `firstPlayerFlag` and `switchInput` (11 bits) each pass through a 2-flop synchronizer. A flop `flag_prev` holds the synced flag from the previous cycle. `buzz_edge` = synced flag & ~`flag_prev`.
- States: IDLE, ARMED, JUDGE, SHOW.
- IDLE:
  - `start`=1 → ARMED; latch `target` into `tgt_q`.
  - `start` in any other state is ignored.
- ARMED:
  - On `buzz_edge` → JUDGE; latch synced player index into `winner` and synced switches into `answer`.
  - A flag already high when armed is not accepted; the player must release and press again.
  - No timeout; the round waits indefinitely.
- JUDGE (1 cycle):
  - `correct` ← (`answer` == `tgt_q`).
  - If correct, increment the winner's score, saturating at 255.
  - Load the display counter with `LOCK_CYCLES-1`, then go to SHOW.
- SHOW:
  - `p_led` = one-hot(`winner`).
  - Counter decrements each cycle.
  - On the cycle the counter is 0: `done`=1, `p_led`←0, → IDLE.
  - Buzzes during SHOW are ignored.
- Reset values (async, all outputs):
  - `busy`=0, `done`=0, `correct`=0, `winner`=0, `answer`=0, `scores`=0, `p_led`=0.
  - FSM=IDLE; synchronizers and `flag_prev` = 0.
- Reset mid-round: the round is abandoned, scores clear, and no `done` is generated.

## Timing

- `start` at cycle N → `busy`=1 at N+1.
- Async flag rise → synced flag 2 cycles later. `buzz_edge` asserts the same cycle; FSM=JUDGE next cycle. Edge-to-JUDGE latency is 3 cycles ±1 of sampling.
- `correct` and `scores` update at the end of JUDGE and are visible on the first SHOW cycle.
- SHOW lasts exactly `LOCK_CYCLES` cycles. `done` is high on the last SHOW cycle. `busy`=0 the following cycle.
- Earliest re-arm: `start` on the first cycle `busy`=0.
- Switches are sampled from the same synchronizer stage as the flag edge. The controller holds switches stable while the flag is high, so no skew handling is required.

## Structure

- Shared package `hex_pkg`:
  - FSM state enum (IDLE, ARMED, JUDGE, SHOW).
  - `PLAYER_W`=2, `NUM_PLAYERS`=4, `SCORE_W`=8.
  - `DEFAULT_LOCK_CYCLES`.
- Sub-module `sync2` (parameterised width, 2-flop, async reset) is instantiated once for the 11 input bits.
- Score registers and the saturating increment stay in the top module.

## Test plan

Benches use `LOCK_CYCLES`=4.

- Normal win: `target`=0x3C; player 2 buzzes with `switchInput`=0x3C → `winner`=2, `answer`=0x3C, `correct`=1, `s2`=1, `p_led`=4'b0100 for 4 cycles, one `done` pulse, then `busy`=0.
- Wrong answer: `target`=0xA5; player 1 answers 0x5A → `correct`=0, scores unchanged, `p_led`=4'b0010 for 4 cycles.
- Flag held across arm: `playerInputFlag` high before `start` and still high after → no capture. Release, then press with player 0 → captured as player 0.
- Ignored events: `start` pulses in ARMED and in SHOW, and buzzes during SHOW → no state change, exactly one `done` per round.
- Saturation: 256 correct rounds for player 3 → `s3` stays 255 after the 255th round.
- Reset mid-SHOW: assert `reset` asynchronously (between edges) during SHOW → all outputs 0 immediately, no `done`, and a subsequent `start` works normally.

Source files
------------

// File: rtl/hex_pkg.sv
// Shared types and constants for the buzz-in answer judge.
// State encoding, player/score widths and the default display window length.
package hex_pkg;

    localparam int PLAYER_W            = 2;
    localparam int NUM_PLAYERS         = 4;
    localparam int SCORE_W             = 8;
    localparam int DATA_W              = 8;
    localparam int DEFAULT_LOCK_CYCLES = 50_000_000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        JUDGE = 2'd2,
        SHOW  = 2'd3
    } judge_state_t;

    function automatic logic [NUM_PLAYERS-1:0] player_onehot(input logic [PLAYER_W-1:0] idx);
        return NUM_PLAYERS'(1) << idx;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a bundle of asynchronous inputs.
// Each bit is synchronized independently; callers rely on the source holding the bundle stable.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/player_answer_judge.sv
// Judges one buzz-in round: latches the first buzzing player and switch value, scores it
// against the CPU target, and lights that player's LED for a fixed display window.
module player_answer_judge
    import hex_pkg::*;
#(
    parameter int LOCK_CYCLES = DEFAULT_LOCK_CYCLES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [DATA_W-1:0]             target,
    input  logic                          playerInputFlag,
    input  logic [PLAYER_W-1:0]           firstPlayerFlag,
    input  logic [DATA_W-1:0]             switchInput,
    output logic                          busy,
    output logic                          done,
    output logic                          correct,
    output logic [PLAYER_W-1:0]           winner,
    output logic [DATA_W-1:0]             answer,
    output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
    output logic [NUM_PLAYERS-1:0]        p_led
);

    localparam int SYNC_W = 1 + PLAYER_W + DATA_W;
    localparam int CNT_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_CYCLES - 1);

    logic [SYNC_W-1:0]   sync_in;
    logic [SYNC_W-1:0]   sync_out;
    logic                flag_s;
    logic [PLAYER_W-1:0] player_s;
    logic [DATA_W-1:0]   switch_s;
    logic                buzz_edge;

    judge_state_t         state_q,     state_d;
    logic [DATA_W-1:0]    tgt_q,       tgt_d;
    logic [CNT_W-1:0]     cnt_q,       cnt_d;
    logic [PLAYER_W-1:0]  winner_q,    winner_d;
    logic [DATA_W-1:0]    answer_q,    answer_d;
    logic                 correct_q,   correct_d;
    logic                 done_q,      done_d;
    logic                 busy_q,      busy_d;
    logic [NUM_PLAYERS-1:0] p_led_q,   p_led_d;
    logic                 flag_prev_q, flag_prev_d;
    logic [SCORE_W-1:0]   score_q [NUM_PLAYERS];
    logic [SCORE_W-1:0]   score_d [NUM_PLAYERS];

    assign sync_in = {playerInputFlag, firstPlayerFlag, switchInput};

    sync2 #(
        .WIDTH(SYNC_W)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (sync_in),
        .q    (sync_out)
    );

    // Switches come from the same stage as the flag, so the capture matches the edge.
    assign flag_s    = sync_out[SYNC_W-1];
    assign player_s  = sync_out[DATA_W +: PLAYER_W];
    assign switch_s  = sync_out[DATA_W-1:0];
    assign buzz_edge = flag_s & ~flag_prev_q;

    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cnt_d       = cnt_q;
        winner_d    = winner_q;
        answer_d    = answer_q;
        correct_d   = correct_q;
        flag_prev_d = flag_s;
        score_d     = score_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ARMED;
                    tgt_d   = target;
                end
            end
            ARMED: begin
                if (buzz_edge) begin
                    state_d  = JUDGE;
                    winner_d = player_s;
                    answer_d = switch_s;
                end
            end
            JUDGE: begin
                correct_d = (answer_q == tgt_q);
                if ((answer_q == tgt_q) && (score_q[winner_q] != '1)) begin
                    score_d[winner_q] = score_q[winner_q] + SCORE_W'(1);
                end
                cnt_d   = CNT_LOAD;
                state_d = SHOW;
            end
            SHOW: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered, so they are derived from the state being entered.
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == SHOW) && (cnt_d == '0);
        p_led_d = (state_d == SHOW) ? player_onehot(winner_d) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tgt_q       <= '0;
            cnt_q       <= '0;
            winner_q    <= '0;
            answer_q    <= '0;
            correct_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            p_led_q     <= '0;
            flag_prev_q <= 1'b0;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cnt_q       <= cnt_d;
            winner_q    <= winner_d;
            answer_q    <= answer_d;
            correct_q   <= correct_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            p_led_q     <= p_led_d;
            flag_prev_q <= flag_prev_d;
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                score_q[i] <= score_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_scores
        assign scores[g*SCORE_W +: SCORE_W] = score_q[g];
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign correct = correct_q;
    assign winner  = winner_q;
    assign answer  = answer_q;
    assign p_led   = p_led_q;

endmodule
